// File: rtl/pong_match_ctl.sv
// Pong match sequencer: game-state FSM, score counters and serve countdown.
// Every output comes straight from a flop; start_i wins over a same-cycle frame tick.
module pong_match_ctl #(
    parameter int SCORE_LIMIT        = 9,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int SCORE_W            = 4,
    parameter int DLY_W              = 7
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               frame_tick_i,
    input  logic               miss_p1_i,
    input  logic               miss_p2_i,
    output logic               game_active_o,
    output logic               ball_reset_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic [1:0]         winner_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [SCORE_W-1:0] LIMIT    = SCORE_W'(SCORE_LIMIT);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [SCORE_W-1:0] p1_inc, p2_inc;
    logic [1:0]         win_q, win_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               br_q, br_d;
    logic               ga_q, ga_d;

    assign p1_inc = p1_q + SCORE_W'(1);
    assign p2_inc = p2_q + SCORE_W'(1);

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    state_d = S_SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                    win_d   = 2'd0;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick_i) begin
                    if (cnt_q == DLY_LAST) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DLY_W'(1);
                    end
                end
            end
            S_PLAY: begin
                unique case (1'b1)
                    (miss_p1_i && miss_p2_i): begin
                        state_d = S_SERVE;
                    end
                    (miss_p1_i && !miss_p2_i): begin
                        p2_d    = p2_inc;
                        dir_d   = 1'b0;
                        state_d = (p2_inc == LIMIT) ? S_OVER : S_SERVE;
                        if (p2_inc == LIMIT) win_d = 2'd2;
                    end
                    (miss_p2_i && !miss_p1_i): begin
                        p1_d    = p1_inc;
                        dir_d   = 1'b1;
                        state_d = (p1_inc == LIMIT) ? S_OVER : S_SERVE;
                        if (p1_inc == LIMIT) win_d = 2'd1;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
        br_d = (state_d != S_PLAY);
        ga_d = (state_d == S_SERVE) || (state_d == S_PLAY);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= 2'd0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            br_q    <= 1'b1;
            ga_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            br_q    <= br_d;
            ga_q    <= ga_d;
        end
    end

    assign state_o       = state_q;
    assign p1_score_o    = p1_q;
    assign p2_score_o    = p2_q;
    assign winner_o      = win_q;
    assign serve_dir_o   = dir_q;
    assign ball_reset_o  = br_q;
    assign game_active_o = ga_q;

endmodule

// File: tb/tb_pong_match_ctl.sv
// Directed bench for pong_match_ctl with a queue of expected output snapshots.
// Short serve delay (3 frames) keeps the match sequences compact.
module tb_pong_match_ctl;

    localparam int LIM = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       m1 = 1'b0;
    logic       m2 = 1'b0;
    logic       ga, br, dir;
    logic [3:0] p1, p2;
    logic [1:0] win, st;

    typedef struct packed {
        logic [1:0] st;
        logic       br;
        logic       ga;
        logic       dir;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [1:0] win;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pong_match_ctl #(
        .SCORE_LIMIT(LIM),
        .SERVE_DELAY_FRAMES(3),
        .SCORE_W(4),
        .DLY_W(7)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .frame_tick_i(tick),
        .miss_p1_i(m1),
        .miss_p2_i(m2),
        .game_active_o(ga),
        .ball_reset_o(br),
        .serve_dir_o(dir),
        .p1_score_o(p1),
        .p2_score_o(p2),
        .winner_o(win),
        .state_o(st)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input string f,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, act, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t x;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        x = q.pop_front();
        cmp(tag, "state", {2'b0, st}, {2'b0, x.st});
        cmp(tag, "ball_reset", {3'b0, br}, {3'b0, x.br});
        cmp(tag, "game_active", {3'b0, ga}, {3'b0, x.ga});
        cmp(tag, "serve_dir", {3'b0, dir}, {3'b0, x.dir});
        cmp(tag, "p1", p1, x.p1);
        cmp(tag, "p2", p2, x.p2);
        cmp(tag, "winner", {2'b0, win}, {2'b0, x.win});
    endtask

    task automatic step(input logic s, input logic t, input logic a,
                        input logic b, input string tag);
        start = s;
        tick  = t;
        m1    = a;
        m2    = b;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        tick  = 1'b0;
        m1    = 1'b0;
        m2    = 1'b0;
        check(tag);
    endtask

    task automatic set_reset_exp();
        e = '{st: 2'd0, br: 1'b1, ga: 1'b0, dir: 1'b0,
              p1: 4'd0, p2: 4'd0, win: 2'd0};
    endtask

    task automatic serve3();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                e.st = 2'd2;
                e.br = 1'b0;
            end
            step(1'b0, 1'b1, 1'b0, 1'b0, "serve_tick");
        end
    endtask

    task automatic p1_misses();
        e.p2  = e.p2 + 4'd1;
        e.dir = 1'b0;
        e.br  = 1'b1;
        if (e.p2 == 4'(LIM)) begin
            e.st  = 2'd3;
            e.ga  = 1'b0;
            e.win = 2'd2;
        end else begin
            e.st = 2'd1;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "miss_p1");
    endtask

    task automatic p2_misses();
        e.p1  = e.p1 + 4'd1;
        e.dir = 1'b1;
        e.br  = 1'b1;
        if (e.p1 == 4'(LIM)) begin
            e.st  = 2'd3;
            e.ga  = 1'b0;
            e.win = 2'd1;
        end else begin
            e.st = 2'd1;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, "miss_p2");
    endtask

    task automatic new_match(input logic with_tick);
        e = '{st: 2'd1, br: 1'b1, ga: 1'b1, dir: 1'b0,
              p1: 4'd0, p2: 4'd0, win: 2'd0};
        step(1'b1, with_tick, 1'b0, 1'b0, "start");
    endtask

    initial begin
        set_reset_exp();
        repeat (3) @(posedge clk);
        #1;
        q.push_back(e);
        check("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        step(1'b0, 1'b1, 1'b1, 1'b1, "idle_ignore");

        new_match(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "tick1");
        step(1'b0, 1'b0, 1'b1, 1'b1, "serve_miss");
        step(1'b1, 1'b0, 1'b0, 1'b0, "serve_start");
        step(1'b0, 1'b1, 1'b0, 1'b0, "tick2");
        e.st = 2'd2;
        e.br = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, "tick3");
        step(1'b1, 1'b0, 1'b0, 1'b0, "play_start");

        p1_misses();
        serve3();
        p2_misses();
        serve3();
        e.st = 2'd1;
        e.br = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, "both_miss");
        serve3();
        for (int i = 0; i < 8; i++) begin
            p2_misses();
            if (e.st != 2'd3) serve3();
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, "over_hold1");
        step(1'b0, 1'b0, 1'b0, 1'b1, "over_hold2");

        new_match(1'b1);
        serve3();

        for (int i = 0; i < 4; i++) begin
            p2_misses();
            serve3();
        end
        for (int i = 0; i < 7; i++) begin
            p1_misses();
            serve3();
        end
        #2;
        rst_n = 1'b0;
        #1;
        set_reset_exp();
        q.push_back(e);
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, "post_reset");

        new_match(1'b0);
        serve3();
        for (int i = 0; i < LIM; i++) begin
            p1_misses();
            if (e.st != 2'd3) serve3();
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, "p2_win_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
